// File: rtl/sysarray_pkg.sv
// rtl/sysarray_pkg.sv - shared state encoding and default latencies for the systolic array head controller
package sysarray_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_WAIT_TILE,
    ST_RUN,
    ST_ACCUM,
    ST_COMPARE,
    ST_DONE
  } head_state_t;

  localparam int ADD_LAT_DEFAULT = 10;
  localparam int CMP_LAT_DEFAULT = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sysarray_head_ctrl.sv
// rtl/sysarray_head_ctrl.sv - sequences flush, tile accumulation, mean and prune compare for one attention head
module sysarray_head_ctrl
  import sysarray_pkg::*;
#(
  parameter int NUM_TILES = 4,
  parameter int ADD_LAT   = ADD_LAT_DEFAULT,
  parameter int CMP_LAT   = CMP_LAT_DEFAULT
) (
  input  logic       clk,
  input  logic       _reset,
  input  logic       start,
  input  logic       abort,
  input  logic       int_mode,
  input  logic       tile_valid,
  input  logic       head_prune_in,
  output logic       tile_ready,
  output logic       add_flag,
  output logic       int_flag,
  output logic       flush_acc_n,
  output logic       mean_enable,
  output logic       compare_flag,
  output logic [3:0] tile_idx,
  output logic       busy,
  output logic       done,
  output logic       prune_head
);

  localparam int CNT_W = $clog2(max_int(ADD_LAT, CMP_LAT)) + 1;
  localparam logic [CNT_W-1:0] ADD_LAST  = CNT_W'(ADD_LAT - 1);
  localparam logic [CNT_W-1:0] CMP_LAST  = CNT_W'(CMP_LAT - 1);
  localparam logic [3:0]       LAST_TILE = 4'(NUM_TILES - 1);

  head_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       idx_nxt;
  logic             int_nxt, prune_nxt;

  always_ff @(posedge clk) begin
    if (_reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      tile_idx   <= '0;
      int_flag   <= 1'b0;
      prune_head <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      tile_idx   <= idx_nxt;
      int_flag   <= int_nxt;
      prune_head <= prune_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = tile_idx;
    int_nxt   = int_flag;
    prune_nxt = prune_head;
    // abort outranks every in-flight transition, including the prune capture
    if (abort && state != ST_IDLE) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            int_nxt   = int_mode;
            idx_nxt   = '0;
            state_nxt = ST_FLUSH;
          end
        end
        ST_FLUSH: state_nxt = ST_WAIT_TILE;
        ST_WAIT_TILE: begin
          if (tile_valid) begin
            cnt_nxt   = '0;
            state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (cnt == ADD_LAST) state_nxt = ST_ACCUM;
          else                 cnt_nxt   = cnt + CNT_W'(1);
        end
        ST_ACCUM: begin
          if (tile_idx == LAST_TILE) begin
            cnt_nxt   = '0;
            state_nxt = ST_COMPARE;
          end else begin
            idx_nxt   = tile_idx + 4'd1;
            state_nxt = ST_FLUSH;
          end
        end
        ST_COMPARE: begin
          if (cnt == CMP_LAST) begin
            prune_nxt = head_prune_in;
            state_nxt = ST_DONE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign tile_ready   = (state == ST_WAIT_TILE);
  assign add_flag     = (state == ST_RUN);
  assign flush_acc_n  = (state != ST_FLUSH);
  assign mean_enable  = (state == ST_ACCUM);
  assign compare_flag = (state == ST_COMPARE);
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);

endmodule
